// File: rtl/counter_cmd_arbiter_pkg.sv
// Shared types for the counter command arbiter: command codes, FSM states
// and a small classification helper.
package counter_ctrl_pkg;

    // Per-requester command encoding as seen on the Cmd bus.
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_UP   = 2'b10,
        CMD_DOWN = 2'b11
    } cmd_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True for the commands that step the counter.
    function automatic logic is_count(input cmd_e c);
        return (c == CMD_UP) || (c == CMD_DOWN);
    endfunction

endpackage

// File: rtl/counter_cmd_arbiter_arb.sv
// Round-robin arbiter. The grant is combinational from Req and the rotating
// pointer; the pointer moves to the slot after the winner when advance is set.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N_REQ-1:0] Req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan from the pointer upward with wrap; first requester seen wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant   = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && Req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = cand;
            end
        end
    end

    // Priority pointer: reset favours requester 0, then rotates past each winner.
    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (Reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= PTR_W'((int'(win_idx) + 1) % N_REQ);
        end
    end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Shares one up/down loadable counter between N_REQ requesters. A round-robin
// arbiter picks a requester, the FSM latches its command and drives the
// counter pins, and the final count is returned with a one-cycle Done pulse.
module counter_cmd_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [2*N_REQ-1:0]       Cmd,
    input  logic [N_REQ*WIDTH-1:0]   Arg,
    output logic [N_REQ-1:0]         Gnt,
    output logic [N_REQ-1:0]         Done,
    output logic [WIDTH-1:0]         Result,
    output logic                     Busy,
    output logic                     CntEnable,
    output logic                     CntLoad,
    output logic                     CntUpDn,
    output logic [WIDTH-1:0]         CntData,
    input  logic [WIDTH-1:0]         CntQ
);

    state_e             state;
    cmd_e               cmd_q;
    logic [WIDTH-1:0]   arg_q;
    logic [WIDTH-1:0]   steps_q;
    logic [N_REQ-1:0]   gnt_q;

    logic [N_REQ-1:0]   arb_gnt;
    logic [1:0]         sel_cmd_bits;
    cmd_e               sel_cmd;
    logic [WIDTH-1:0]   sel_arg;
    logic               start;

    // A new command is taken only from IDLE; requests arriving while busy wait.
    assign start = (state == ST_IDLE) && (|Req);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .advance (start),
        .grant   (arb_gnt)
    );

    // Select the winner's command and argument with a one-hot AND-OR mux.
    always_comb begin
        sel_cmd_bits = '0;
        sel_arg      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_cmd_bits = sel_cmd_bits | Cmd[i*2 +: 2];
                sel_arg      = sel_arg | Arg[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_cmd = cmd_e'(sel_cmd_bits);

    // Sequencer: latch the granted command, run it to completion, then release.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            arg_q   <= '0;
            steps_q <= '0;
            gnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        gnt_q   <= arb_gnt;
                        cmd_q   <= sel_cmd;
                        arg_q   <= sel_arg;
                        steps_q <= sel_arg;
                        if (sel_cmd == CMD_LOAD) begin
                            state <= ST_LOAD;
                        end else if (is_count(sel_cmd) && (sel_arg != '0)) begin
                            state <= ST_COUNT;
                        end else begin
                            // NOP and zero-step counts complete without touching the counter.
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_DONE;
                end
                ST_COUNT: begin
                    steps_q <= steps_q - 1'b1;
                    // Leaving on the last enabled cycle gives exactly Arg counter steps.
                    if (steps_q == WIDTH'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    gnt_q <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counter pins and handshake outputs decode directly from the state.
    always_comb begin
        Busy      = (state != ST_IDLE);
        Gnt       = gnt_q;
        CntEnable = 1'b0;
        CntLoad   = 1'b0;
        CntUpDn   = 1'b0;
        CntData   = '0;
        Done      = '0;
        Result    = '0;
        case (state)
            ST_LOAD: begin
                CntEnable = 1'b1;
                CntLoad   = 1'b1;
                CntData   = arg_q;
            end
            ST_COUNT: begin
                CntEnable = 1'b1;
                CntUpDn   = (cmd_q == CMD_UP);
            end
            ST_DONE: begin
                // The counter has already absorbed the last step, so CntQ is final here.
                Done   = gnt_q;
                Result = CntQ;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Self-checking bench for counter_cmd_arbiter: a table of single-requester
// vectors, hand sequences for arbitration order, reset and latched-command
// corner cases, and a randomized multi-requester phase checked against an
// arithmetic reference model. The shared counter lives in the bench.
module tb_counter_cmd_arbiter;
    import counter_ctrl_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [N-1:0]     Req;
    logic [2*N-1:0]   Cmd;
    logic [N*W-1:0]   Arg;
    logic [N-1:0]     Gnt;
    logic [N-1:0]     Done;
    logic [W-1:0]     Result;
    logic             Busy;
    logic             CntEnable;
    logic             CntLoad;
    logic             CntUpDn;
    logic [W-1:0]     CntData;
    logic [W-1:0]     cnt_q;

    counter_cmd_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Req       (Req),
        .Cmd       (Cmd),
        .Arg       (Arg),
        .Gnt       (Gnt),
        .Done      (Done),
        .Result    (Result),
        .Busy      (Busy),
        .CntEnable (CntEnable),
        .CntLoad   (CntLoad),
        .CntUpDn   (CntUpDn),
        .CntData   (CntData),
        .CntQ      (cnt_q)
    );

    always #5 Clock = ~Clock;

    // Shared up/down loadable counter driven by the Cnt* pins.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)            cnt_q <= '0;
        else if (CntEnable) begin
            if (CntLoad)      cnt_q <= CntData;
            else if (CntUpDn) cnt_q <= cnt_q + 1'b1;
            else              cnt_q <= cnt_q - 1'b1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Structural rules that must hold every cycle outside reset.
    logic inv_ok;
    assign inv_ok = $onehot0(Gnt) && $onehot0(Done) && ((Done & ~Gnt) == '0)
                    && (Busy == (Gnt != '0)) && (!CntEnable || Busy);

    always @(negedge Clock) begin
        if (!Reset) check("invariants", {31'b0, inv_ok}, 32'd1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          req;
        cmd_e        cmd;
        logic [7:0]  arg;
        logic [7:0]  exp_res;
        int          exp_lat;
        int          exp_en;
        int          exp_up;
        int          exp_ld;
    } vec_t;

    vec_t tbl[8];
    int   got_idx[$];
    logic [7:0] got_res[$];
    logic [7:0] model_q;

    // Reference arithmetic for one command applied to the counter value.
    function automatic logic [7:0] apply(input logic [7:0] q, input cmd_e c, input logic [7:0] a);
        case (c)
            CMD_LOAD: return a;
            CMD_UP:   return q + a;
            CMD_DOWN: return q - a;
            default:  return q;
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        Req   = '0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    // One requester, one command; measures latency and counter-pin activity.
    task automatic run_vec(input vec_t v, input string tag);
        int lat = 0, en = 0, up = 0, ld = 0, gc = 0;
        logic [7:0] res = 8'h00, data = 8'h00;
        Cmd[v.req*2 +: 2] = v.cmd;
        Arg[v.req*W +: W] = v.arg;
        Req[v.req]        = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge Clock); #1;
            if (CntEnable)            en++;
            if (CntEnable && CntUpDn) up++;
            if (CntLoad) begin ld++; data = CntData; end
            if (Gnt == N'(1 << v.req)) gc++;
            if (Done[v.req]) begin
                lat        = k;
                res        = Result;
                Req[v.req] = 1'b0;
                break;
            end
        end
        Req[v.req] = 1'b0;
        check($sformatf("%s latency", tag), lat, v.exp_lat);
        check($sformatf("%s result", tag), {24'b0, res}, {24'b0, v.exp_res});
        check($sformatf("%s enable cycles", tag), en, v.exp_en);
        check($sformatf("%s up cycles", tag), up, v.exp_up);
        check($sformatf("%s load cycles", tag), ld, v.exp_ld);
        check($sformatf("%s grant cycles", tag), gc, v.exp_lat);
        check($sformatf("%s load data", tag), {24'b0, data},
              {24'b0, (v.cmd == CMD_LOAD) ? v.arg : 8'h00});
        @(posedge Clock); #1;
        check($sformatf("%s idle after", tag), {31'b0, Busy}, 32'd0);
    endtask

    // Serve all currently raised requests; records Done order and results.
    task automatic serve(input string tag);
        got_idx.delete();
        got_res.delete();
        for (int k = 0; k < 400 && Req != '0; k++) begin
            @(posedge Clock); #1;
            for (int i = 0; i < N; i++) begin
                if (Done[i]) begin
                    got_idx.push_back(i);
                    got_res.push_back(Result);
                    Req[i] = 1'b0;
                end
            end
        end
        if (Req != '0) begin
            check($sformatf("%s timeout pending", tag), {28'b0, Req}, 32'd0);
            Req = '0;
        end
        @(posedge Clock); #1;
    endtask

    function automatic int idx_at(input int j);
        return (j < got_idx.size()) ? got_idx[j] : -1;
    endfunction

    function automatic logic [7:0] res_at(input int j);
        return (j < got_res.size()) ? got_res[j] : 8'hxx;
    endfunction

    initial begin
        int t1, t2, nd;
        logic [7:0] r1, r2;
        int m_ptr;

        tbl[0] = '{req:0, cmd:CMD_LOAD, arg:8'h5A, exp_res:8'h5A, exp_lat:2, exp_en:1, exp_up:0, exp_ld:1};
        tbl[1] = '{req:0, cmd:CMD_LOAD, arg:8'hFE, exp_res:8'hFE, exp_lat:2, exp_en:1, exp_up:0, exp_ld:1};
        tbl[2] = '{req:1, cmd:CMD_UP,   arg:8'd3,  exp_res:8'h01, exp_lat:4, exp_en:3, exp_up:3, exp_ld:0};
        tbl[3] = '{req:2, cmd:CMD_DOWN, arg:8'd2,  exp_res:8'hFF, exp_lat:3, exp_en:2, exp_up:0, exp_ld:0};
        tbl[4] = '{req:3, cmd:CMD_UP,   arg:8'd0,  exp_res:8'hFF, exp_lat:1, exp_en:0, exp_up:0, exp_ld:0};
        tbl[5] = '{req:1, cmd:CMD_NOP,  arg:8'h77, exp_res:8'hFF, exp_lat:1, exp_en:0, exp_up:0, exp_ld:0};
        tbl[6] = '{req:0, cmd:CMD_DOWN, arg:8'd1,  exp_res:8'hFE, exp_lat:2, exp_en:1, exp_up:0, exp_ld:0};
        tbl[7] = '{req:3, cmd:CMD_UP,   arg:8'd1,  exp_res:8'hFF, exp_lat:2, exp_en:1, exp_up:1, exp_ld:0};

        Reset = 1'b1;
        Req   = '0;
        Cmd   = '0;
        Arg   = '0;
        #12;
        check("reset Gnt", {28'b0, Gnt}, 32'd0);
        check("reset Done", {28'b0, Done}, 32'd0);
        check("reset Busy", {31'b0, Busy}, 32'd0);
        check("reset Cnt ctrl", {29'b0, CntEnable, CntLoad, CntUpDn}, 32'd0);
        check("reset CntData", {24'b0, CntData}, 32'd0);
        check("reset Result", {24'b0, Result}, 32'd0);
        @(posedge Clock); #1 Reset = 1'b0;

        // Table of single-requester commands, including wrap and zero-step cases.
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        model_q = 8'hFF;

        // All four request UP 1 at once, twice: round-robin order 0..3 each time.
        for (int i = 0; i < N; i++) begin
            Cmd[i*2 +: 2] = CMD_UP;
            Arg[i*W +: W] = 8'd1;
        end
        for (int r = 0; r < 2; r++) begin
            Req = '1;
            serve($sformatf("rr round%0d", r));
            check($sformatf("rr round%0d count", r), got_idx.size(), N);
            for (int j = 0; j < N; j++) begin
                model_q = model_q + 8'd1;
                check($sformatf("rr round%0d order%0d", r, j), idx_at(j), j);
                check($sformatf("rr round%0d result%0d", r, j), {24'b0, res_at(j)}, {24'b0, model_q});
            end
        end
        check("rr final +8", {24'b0, res_at(N-1)}, 32'h07);

        // Command changes after grant are ignored; held Req yields a second grant.
        Cmd[2 +: 2] = CMD_UP;
        Arg[W +: W] = 8'd5;
        Req[1] = 1'b1;
        nd = 0; t1 = 0; t2 = 0; r1 = 8'h00; r2 = 8'h00;
        for (int k = 1; k <= 64; k++) begin
            @(posedge Clock); #1;
            if (k == 2) begin
                Cmd[2 +: 2] = CMD_DOWN;
                Arg[W +: W] = 8'd1;
            end
            if (Done[1]) begin
                nd++;
                if (nd == 1) begin
                    t1 = k; r1 = Result;
                end else begin
                    t2 = k; r2 = Result; Req[1] = 1'b0;
                    break;
                end
            end
        end
        Req[1] = 1'b0;
        check("latched UP5 latency", t1, 6);
        check("latched UP5 result", {24'b0, r1}, {24'b0, model_q + 8'd5});
        check("held Req regrant delay", t2 - t1, 3);
        check("held Req DOWN1 result", {24'b0, r2}, {24'b0, model_q + 8'd4});
        @(posedge Clock); #1;

        // Reset in the middle of DOWN 10.
        Cmd[1:0] = CMD_DOWN;
        Arg[W-1:0] = 8'd10;
        Req[0] = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
        check("mid DOWN10 busy", {31'b0, Busy}, 32'd1);
        Reset = 1'b1;
        Req   = '0;
        #1;
        check("mid-reset Gnt", {28'b0, Gnt}, 32'd0);
        check("mid-reset Done", {28'b0, Done}, 32'd0);
        check("mid-reset Busy", {31'b0, Busy}, 32'd0);
        check("mid-reset Cnt ctrl", {29'b0, CntEnable, CntLoad, CntUpDn}, 32'd0);
        check("mid-reset counter", {24'b0, Result | cnt_q}, 32'd0);
        @(posedge Clock); #1 Reset = 1'b0;
        nd = 0;
        repeat (3) begin
            @(posedge Clock); #1;
            if (Done != '0) nd++;
        end
        check("no Done after reset", nd, 0);

        // After reset requester 0 outranks requester 3 again.
        Cmd[1:0] = CMD_NOP;
        Cmd[7:6] = CMD_NOP;
        Req = 4'b1001;
        serve("post-reset priority");
        check("post-reset first", idx_at(0), 0);
        check("post-reset second", idx_at(1), 3);
        check("post-reset NOP result", {24'b0, res_at(1)}, 32'd0);
        run_vec('{req:0, cmd:CMD_LOAD, arg:8'h3C, exp_res:8'h3C, exp_lat:2, exp_en:1, exp_up:0, exp_ld:1},
                "post-reset LOAD");

        // Randomized batches against the arithmetic reference model.
        do_reset();
        model_q = 8'h00;
        m_ptr   = 0;
        for (int rnd = 0; rnd < 40; rnd++) begin
            logic [N-1:0] mask, pend;
            cmd_e         rc[N];
            logic [7:0]   ra[N];
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                rc[i] = cmd_e'($urandom_range(0, 3));
                ra[i] = (rc[i] == CMD_LOAD) ? 8'($urandom) : 8'($urandom_range(0, 6));
                Cmd[i*2 +: 2] = rc[i];
                Arg[i*W +: W] = ra[i];
            end
            Req = mask;
            serve($sformatf("rand%0d", rnd));
            pend = mask;
            for (int s = 0; s < N; s++) begin
                int w;
                w = -1;
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && pend[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                end
                if (w >= 0) begin
                    pend[w] = 1'b0;
                    m_ptr   = (w + 1) % N;
                    model_q = apply(model_q, rc[w], ra[w]);
                    check($sformatf("rand%0d winner%0d", rnd, s), idx_at(s), w);
                    check($sformatf("rand%0d result%0d", rnd, s), {24'b0, res_at(s)}, {24'b0, model_q});
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
